// File: rtl/traffic_input_conditioner.sv
// Input front-end for the intersection controller: two-flop synchronisers,
// per-channel debounce counters, sticky pedestrian/left-turn requests with ack.
module traffic_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic emergency_raw,
  input  logic power_outage_raw,
  input  logic pedestrian_raw,
  input  logic left_turn_raw,
  input  logic ped_ack,
  input  logic left_ack,
  output logic emergency,
  output logic power_outage,
  output logic emergency_rise,
  output logic pedestrian_req,
  output logic left_turn_req
);

  localparam int NCH = 4;
  localparam int CH_EMER = 0;
  localparam int CH_PWR  = 1;
  localparam int CH_PED  = 2;
  localparam int CH_LEFT = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic mask_req(input logic pend, input logic emer, input logic pwr);
    return pend & ~emer & ~pwr;
  endfunction

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync_p0;
  logic [NCH-1:0]   sync_p1;
  logic [NCH-1:0]   stable_p2;
  logic [CNT_W-1:0] cnt_p2 [NCH];
  logic [NCH-1:0]   flip;
  logic [NCH-1:0]   rise;
  logic             ped_pend;
  logic             left_pend;
  logic             emer_rise_q;

  assign raw = {left_turn_raw, pedestrian_raw, power_outage_raw, emergency_raw};

  // Debounce decision: a channel flips once its synchronised input has
  // disagreed with the stable value for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    flip = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      flip[ch] = (sync_p1[ch] != stable_p2[ch]) && (cnt_p2[ch] == CNT_LAST);
    end
    rise = flip & ~stable_p2;
  end

  // Stage p0/p1: synchroniser, stage p2: debounced value and its counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      for (int ch = 0; ch < NCH; ch++) cnt_p2[ch] <= '0;
    end else begin
      sync_p0   <= raw;
      sync_p1   <= sync_p0;
      stable_p2 <= stable_p2 ^ flip;
      for (int ch = 0; ch < NCH; ch++) begin
        if (sync_p1[ch] == stable_p2[ch] || flip[ch]) cnt_p2[ch] <= '0;
        else                                          cnt_p2[ch] <= cnt_p2[ch] + 1'b1;
      end
    end
  end

  // Request latches: emergency onset beats a new set, a new set beats an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_pend    <= 1'b0;
      left_pend   <= 1'b0;
      emer_rise_q <= 1'b0;
    end else begin
      emer_rise_q <= rise[CH_EMER];
      if (rise[CH_EMER])     ped_pend <= 1'b0;
      else if (rise[CH_PED]) ped_pend <= 1'b1;
      else if (ped_ack)      ped_pend <= 1'b0;
      if (rise[CH_EMER])      left_pend <= 1'b0;
      else if (rise[CH_LEFT]) left_pend <= 1'b1;
      else if (left_ack)      left_pend <= 1'b0;
    end
  end

  assign emergency      = stable_p2[CH_EMER];
  assign power_outage   = stable_p2[CH_PWR];
  assign emergency_rise = emer_rise_q;
  assign pedestrian_req = mask_req(ped_pend, stable_p2[CH_EMER], stable_p2[CH_PWR]);
  assign left_turn_req  = mask_req(left_pend, stable_p2[CH_EMER], stable_p2[CH_PWR]);

endmodule
